// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seven_seg_scan_driver                                      |
// | Description : Multiplexed common-anode 7-segment scanner with dead time, |
// |               leading-zero blanking and frame-aligned word updates.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              digit_code,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_start
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_act;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic                    r_pend_v;

    logic                    w_slot_end;
    logic                    w_boundary;
    logic                    w_xfer;
    logic [NUM_DIGITS-1:0]   w_blank;

    assign w_slot_end = (r_cnt == c_CNT_LAST);
    assign w_boundary = w_slot_end && (r_idx == c_IDX_LAST);
    assign w_xfer     = load_valid && !r_pend_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_act    <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Active word only changes at the frame boundary so a frame never tears.
            if (w_boundary) begin
                if (r_pend_v) begin
                    r_act    <= r_pend;
                    r_pend_v <= 1'b0;
                end else if (w_xfer) begin
                    r_act <= load_data;
                end
            end else if (w_xfer) begin
                r_pend   <= load_data;
                r_pend_v <= 1'b1;
            end
        end
    end

    // Scan from the top digit down, tracking whether everything above is zero.
    always_comb begin : p_blank
        logic v_zero_run;
        w_blank    = '0;
        v_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v_zero_run = v_zero_run && (r_act[4*k +: 4] == 4'd0);
            w_blank[k] = (r_act[4*k +: 4] > 4'd9) ||
                         ((BLANK_LEADING != 0) && (k > 0) && v_zero_run);
        end
    end

    always_comb begin
        digit_code = 4'd0;
        anode_n    = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                digit_code = r_act[4*k +: 4];
                if ((r_cnt != '0) && !w_blank[k]) begin
                    anode_n[k] = 1'b0;
                end
            end
        end
    end

    assign load_ready  = !r_pend_v;
    assign frame_start = (r_cnt == '0) && (r_idx == '0);

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_seven_seg_scan_driver                                   |
// | Description : Self-checking bench for seven_seg_scan_driver (4 digits,   |
// |               4 cycles per slot) against a time-indexed reference model. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_seven_seg_scan_driver;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int FRAME = ND * RD;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data  = 16'h0;
    logic        load_ready;
    logic [3:0]  digit_code;
    logic [3:0]  anode_n;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;

    // Model: cycles since reset, displayed word, pending word.
    int          m_t      = 0;
    logic [15:0] m_act    = 16'h0;
    logic [15:0] m_pend   = 16'h0;
    bit          m_pend_v = 1'b0;
    bit          m_acc    = 1'b0;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_LEADING(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .digit_code (digit_code),
        .anode_n    (anode_n),
        .frame_start(frame_start)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int          ph;
        int          d;
        logic [15:0] upper;
        logic [3:0]  nib;
        bit          blank;
        logic [3:0]  exp_an;
        ph     = m_t % RD;
        d      = (m_t / RD) % ND;
        upper  = m_act >> (4 * d);
        nib    = upper[3:0];
        blank  = (nib > 4'd9) || ((d > 0) && (upper == 16'h0));
        exp_an = (ph == 0 || blank) ? 4'hF : ~(4'b0001 << d);
        check_eq("anode_n",     32'(anode_n),     32'(exp_an));
        check_eq("digit_code",  32'(digit_code),  32'(nib));
        check_eq("frame_start", 32'(frame_start), 32'(ph == 0 && d == 0));
        check_eq("load_ready",  32'(load_ready),  32'(!m_pend_v));
    endtask

    // One clock: update the model with the inputs the DUT sees, then compare.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_t      = 0;
            m_act    = 16'h0;
            m_pend_v = 1'b0;
            m_acc    = 1'b0;
        end else begin
            m_acc = load_valid && !m_pend_v;
            if ((m_t % FRAME) == FRAME - 1) begin
                if (m_pend_v) begin
                    m_act    = m_pend;
                    m_pend_v = 1'b0;
                end else if (m_acc) begin
                    m_act = load_data;
                end
            end else if (m_acc) begin
                m_pend   = load_data;
                m_pend_v = 1'b1;
            end
            m_t++;
        end
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic load_word(input logic [15:0] w);
        bit done;
        done       = 1'b0;
        load_valid = 1'b1;
        load_data  = w;
        for (int i = 0; i < 4 * FRAME && !done; i++) begin
            step();
            if (m_acc) done = 1'b1;
        end
        load_valid = 1'b0;
        check_eq("load_accept", 32'(done), 32'd1);
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < FRAME && (m_t % FRAME) != p; i++) step();
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        int          r;
        w = 16'h0;
        for (int k = 0; k < ND; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3)       w[4*k +: 4] = 4'd0;
            else if (r == 3) w[4*k +: 4] = 4'($urandom_range(10, 15));
            else             w[4*k +: 4] = 4'($urandom_range(1, 9));
        end
        return w;
    endfunction

    initial begin
        // Reset and release.
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        run(1);

        // Mid-frame load, then leading-zero and invalid-nibble words.
        run(4);
        load_word(16'h1234);
        run(2 * FRAME);
        load_word(16'h0070);
        run(2 * FRAME);
        load_word(16'h0000);
        run(2 * FRAME);
        load_word(16'h12A4);
        run(2 * FRAME);

        // Back-to-back words: the second waits for the first to go active.
        load_word(16'h1111);
        load_word(16'h2222);
        run(3 * FRAME);

        // Load landing exactly on the boundary cycle.
        wait_phase(FRAME - 1);
        load_word(16'h5678);
        run(FRAME + 2);

        // Reset during digit 2 lit phase with a word pending.
        wait_phase(2);
        load_word(16'h4321);
        wait_phase(9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(2 * FRAME);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if (!load_valid && $urandom_range(0, 2) == 0) begin
                load_valid = 1'b1;
                load_data  = rand_word();
            end
            reset = ($urandom_range(0, 299) == 0);
            step();
            if (m_acc) load_valid = 1'b0;
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
